// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions for the data-memory controller:
// opcodes, access sizes, exception bit indices and FSM states.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational op/address decode: access size, write lanes,
// misalignment flag and load-data extension.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic        wr_i,
  input  logic [31:0] src_i,
  input  logic [31:0] rdata_i,
  output size_e       size_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] ext_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    size_o = SZ_WORD;
    unique case (1'b1)
      (op_i == OP_LB) || (op_i == OP_LBU)
        || (op_i == OP_SB): size_o = SZ_BYTE;
      (op_i == OP_LH) || (op_i == OP_LHU)
        || (op_i == OP_SH): size_o = SZ_HALF;
      (op_i == OP_LW) || (op_i == OP_SW):
        size_o = SZ_WORD;
      default: size_o = SZ_WORD;
    endcase

    misalign_o =
      ((size_o == SZ_HALF) && addr_i[0]) ||
      ((size_o == SZ_WORD) && (addr_i != 2'b00));

    wstrb_o = 4'hF;
    wdata_o = src_i;
    unique case (size_o)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{src_i[7:0]}};
      end
      SZ_HALF: begin
        wstrb_o = 4'b0011 << addr_i;
        wdata_o = {2{src_i[15:0]}};
      end
      default: wstrb_o = 4'hF;
    endcase
    if (!wr_i) wstrb_o = 4'h0;

    b = rdata_i[7:0];
    unique case (addr_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      default: b = rdata_i[31:24];
    endcase
    h = addr_i[1] ? rdata_i[31:16]
                  : rdata_i[15:0];

    ext_o = rdata_i;
    unique case (1'b1)
      op_i == OP_LB:  ext_o = {{24{b[7]}}, b};
      op_i == OP_LBU: ext_o = {24'h0, b};
      op_i == OP_LH:  ext_o = {{16{h[15]}}, h};
      op_i == OP_LHU: ext_o = {16'h0, h};
      default:        ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_dsram_ctrl.sv
// MEM-stage SRAM-like data-bus controller with stall and AdEL/AdES.
// Define DSRAM_PERF_CNT_EN for load/store/stall performance counters.
module mem_dsram_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              memen_i,
  input  logic              rmem_i,
  input  logic              wmem_i,
  input  logic [5:0]        op_i,
  input  logic [31:0]       aluout_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [7:0]        except_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  output logic [3:0]        data_wstrb_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic [7:0]        except_o,
  output logic [31:0]       badvaddr_o
`ifdef DSRAM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_load_o,
  output logic [31:0]       perf_store_o,
  output logic [31:0]       perf_stall_o
`endif
);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;

  logic              held;
  logic [5:0]        cur_op;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_src;
  logic              cur_wr;
  size_e             size;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata, ext;
  logic              misalign;
  logic [7:0]        exc;
  logic              access, req, stall;

  // Bus fields come from the latched request once it is in flight.
  assign held     = (state_q == REQ) || (state_q == WAIT);
  assign cur_op   = held ? op_q   : op_i;
  assign cur_addr = held ? addr_q : aluout_i;
  assign cur_src  = held ? src_q  : rdata2_i;
  assign cur_wr   = held ? wr_q   : wmem_i;

  mem_lane_align u_align (
    .op_i       (cur_op),
    .addr_i     (cur_addr[1:0]),
    .wr_i       (cur_wr),
    .src_i      (cur_src),
    .rdata_i    (data_rdata_i),
    .size_o     (size),
    .wstrb_o    (wstrb),
    .wdata_o    (wdata),
    .misalign_o (misalign),
    .ext_o      (ext)
  );

  always_comb begin
    exc = except_i;
    exc[EXC_ADEL] = except_i[EXC_ADEL]
      | (memen_i & rmem_i & misalign);
    exc[EXC_ADES] = except_i[EXC_ADES]
      | (memen_i & wmem_i & misalign);
  end

  assign access = memen_i & ~flush_i & ~|exc;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    src_d   = src_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: if (access) begin
        req     = 1'b1;
        stall   = 1'b1;
        op_d    = op_i;
        addr_d  = aluout_i;
        src_d   = rdata2_i;
        wr_d    = wmem_i;
        state_d = data_addr_ok_i ? WAIT : REQ;
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (flush_i)
          state_d = data_addr_ok_i ? DRAIN : IDLE;
        else if (data_addr_ok_i)
          state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if (!wr_q) rdata_d = ext;
            state_d = DONE;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DONE: if (flush_i || !stall_i) state_d = IDLE;
      DRAIN: begin
        stall = 1'b1;
        if (data_data_ok_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req_o   = rst_i & req;
  assign data_wr_o    = rst_i & cur_wr;
  assign data_size_o  = rst_i ? size : 2'b00;
  assign data_addr_o  = rst_i ? cur_addr[ADDR_W-1:0] : '0;
  assign data_wdata_o = rst_i ? wdata : '0;
  assign data_wstrb_o = rst_i ? wstrb : 4'h0;
  assign rdata_o      = rdata_q;
  assign stall_o      = rst_i & stall;
  assign except_o     = rst_i ? exc : 8'h0;
  assign badvaddr_o   = rst_i ? aluout_i : '0;

`ifdef DSRAM_PERF_CNT_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;
  logic [31:0] stl_cnt_q, stl_cnt_d;
  logic        fin;

  assign fin = (state_q == WAIT)
    && data_data_ok_i && !flush_i;

  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    st_cnt_d  = st_cnt_q;
    stl_cnt_d = stl_cnt_q;
    if (fin && !wr_q) ld_cnt_d = ld_cnt_q + 32'd1;
    if (fin && wr_q)  st_cnt_d = st_cnt_q + 32'd1;
    if (stall_o) stl_cnt_d = stl_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      stl_cnt_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      st_cnt_q  <= st_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign perf_load_o  = ld_cnt_q;
  assign perf_store_o = st_cnt_q;
  assign perf_stall_o = stl_cnt_q;
`endif

endmodule

// File: tb/tb_mem_dsram_ctrl.sv
// Scoreboard bench for mem_dsram_ctrl: expected bus requests and
// load results are queued by stimulus and checked by a monitor.
module tb_mem_dsram_ctrl;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        memen_i = 1'b0;
  logic        rmem_i = 1'b0;
  logic        wmem_i = 1'b0;
  logic [5:0]  op_i = '0;
  logic [31:0] aluout_i = '0;
  logic [31:0] rdata2_i = '0;
  logic [7:0]  except_i = '0;
  logic        data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i = 1'b0;
  logic        data_data_ok_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic [31:0] rdata_o, badvaddr_o;
  logic        stall_o;
  logic [7:0]  except_o;
`ifdef DSRAM_PERF_CNT_EN
  logic [31:0] perf_load, perf_store, perf_stall;
`endif

  mem_dsram_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .memen_i        (memen_i),
    .rmem_i         (rmem_i),
    .wmem_i         (wmem_i),
    .op_i           (op_i),
    .aluout_i       (aluout_i),
    .rdata2_i       (rdata2_i),
    .except_i       (except_i),
    .data_req_o     (data_req_o),
    .data_wr_o      (data_wr_o),
    .data_size_o    (data_size_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_wstrb_o   (data_wstrb_o),
    .data_addr_ok_i (data_addr_ok_i),
    .data_data_ok_i (data_data_ok_i),
    .data_rdata_i   (data_rdata_i),
    .rdata_o        (rdata_o),
    .stall_o        (stall_o),
    .except_o       (except_o),
    .badvaddr_o     (badvaddr_o)
`ifdef DSRAM_PERF_CNT_EN
    ,
    .perf_load_o    (perf_load),
    .perf_store_o   (perf_store),
    .perf_stall_o   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_exp[$];
  logic [31:0] rsp_exp[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  bit          dok_prev = 1'b0;
  req_t        r;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h",
               nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual=event required=none", nm);
  endfunction

  always @(negedge clk) begin
    if (rst_i) begin
      if (stall_o) stall_cnt++;
      if (dok_prev) begin
        if (rsp_exp.size() == 0) fail("rsp_unexpected");
        else chk("rdata", rdata_o, rsp_exp.pop_front());
      end
      if (data_req_o) begin
        if (req_exp.size() == 0) begin
          fail("req_unexpected");
        end else begin
          r = req_exp[0];
          chk("req_wr", data_wr_o, r.wr);
          chk("req_size", data_size_o, r.size);
          chk("req_addr", data_addr_o, r.addr);
          chk("req_strb", data_wstrb_o, r.strb);
          if (r.wr) chk("req_wdata", data_wdata_o, r.wdata);
          if (data_addr_ok_i) void'(req_exp.pop_front());
        end
      end
    end
    dok_prev = rst_i && data_data_ok_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    memen_i = 1'b0;
    rmem_i = 1'b0;
    wmem_i = 1'b0;
    except_i = '0;
  endtask

  task automatic push_req(input logic wr,
                          input logic [1:0] sz,
                          input logic [31:0] a,
                          input logic [3:0] st,
                          input logic [31:0] wd);
    req_t e;
    e.wr = wr;
    e.size = sz;
    e.addr = a;
    e.strb = st;
    e.wdata = wd;
    req_exp.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic st,
                       input logic [31:0] wd);
    memen_i = 1'b1;
    rmem_i = !st;
    wmem_i = st;
    op_i = op;
    aluout_i = a;
    rdata2_i = wd;
  endtask

  task automatic mem_op(input logic [5:0] op,
                        input logic [31:0] a,
                        input logic st,
                        input logic [31:0] wd,
                        input logic [1:0] esz,
                        input logic [3:0] estrb,
                        input logic [31:0] ewd,
                        input int aok_wait,
                        input int dok_wait,
                        input int done_hold,
                        input logic [31:0] bus_rd,
                        input logic [31:0] exp_rd);
    int s0;
    s0 = stall_cnt;
    push_req(st, esz, a, estrb, ewd);
    rsp_exp.push_back(exp_rd);
    issue(op, a, st, wd);
    for (int i = 0; i < aok_wait; i++) begin
      data_addr_ok_i = 1'b0;
      step();
    end
    data_addr_ok_i = 1'b1;
    step();
    data_addr_ok_i = 1'b0;
    for (int i = 1; i < dok_wait; i++) step();
    data_data_ok_i = 1'b1;
    data_rdata_i = bus_rd;
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i = '0;
    for (int i = 0; i < done_hold; i++) begin
      stall_i = 1'b1;
      #3;
      chk("done_hold_stall", stall_o, 0);
      step();
    end
    stall_i = 1'b0;
    #3;
    chk("done_stall", stall_o, 0);
    step();
    clr();
    #3;
    chk("stall_cycles", stall_cnt - s0,
        aok_wait + dok_wait + 1);
    step();
  endtask

  task automatic fault(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic st,
                       input logic [7:0] exc_in,
                       input logic [7:0] exp_exc);
    issue(op, a, st, 32'hA5A5A5A5);
    except_i = exc_in;
    #3;
    chk("flt_except", except_o, exp_exc);
    chk("flt_badvaddr", badvaddr_o, a);
    chk("flt_req", data_req_o, 0);
    chk("flt_stall", stall_o, 0);
    step();
    clr();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    issue(OP_LW, 32'h1236, 1'b0, 32'h0);
    except_i = 8'hFF;
    #3;
    chk("rst_req", data_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_except", except_o, 0);
    chk("rst_badvaddr", badvaddr_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", data_addr_o, 0);
    step();
    clr();
    aluout_i = '0;
    step();
    rst_i = 1'b1;
    step();

    mem_op(OP_LW, 32'h1000, 0, 32'h0, 2'd2, 4'h0, 32'h0,
           0, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    mem_op(OP_SB, 32'h2003, 1, 32'h12345678, 2'd0,
           4'b1000, 32'h78787878,
           0, 1, 0, 32'h0, 32'hDEADBEEF);
    mem_op(OP_LH, 32'h3002, 0, 32'h0, 2'd1, 4'h0, 32'h0,
           1, 1, 0, 32'h80010000, 32'hFFFF8001);
    mem_op(OP_LHU, 32'h3002, 0, 32'h0, 2'd1, 4'h0, 32'h0,
           0, 1, 2, 32'h80010000, 32'h00008001);
    mem_op(OP_LB, 32'h5001, 0, 32'h0, 2'd0, 4'h0, 32'h0,
           0, 1, 0, 32'h00008000, 32'hFFFFFF80);
    mem_op(OP_LBU, 32'h5003, 0, 32'h0, 2'd0, 4'h0, 32'h0,
           0, 2, 0, 32'hAB000000, 32'h000000AB);
    mem_op(OP_SH, 32'h6002, 1, 32'h0000BEEF, 2'd1,
           4'b1100, 32'hBEEFBEEF,
           0, 1, 0, 32'h0, 32'h000000AB);
    mem_op(OP_SW, 32'h8000, 1, 32'h55AA55AA, 2'd2,
           4'hF, 32'h55AA55AA,
           5, 1, 0, 32'h0, 32'h000000AB);

    fault(OP_LW, 32'h4002, 0, 8'h00, 8'h10);
    fault(OP_SH, 32'h4001, 1, 8'h00, 8'h20);
    fault(OP_LW, 32'h4000, 0, 8'h01, 8'h01);

    push_req(0, 2'd2, 32'h9000, 4'h0, 32'h0);
    rsp_exp.push_back(32'h000000AB);
    issue(OP_LW, 32'h9000, 0, 32'h0);
    data_addr_ok_i = 1'b1;
    step();
    data_addr_ok_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    clr();
    #3;
    chk("drain_stall", stall_o, 1);
    step();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'h12121212;
    #3;
    chk("drain_stall_dok", stall_o, 1);
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i = '0;
    #3;
    chk("drain_exit_stall", stall_o, 0);
    step();

    push_req(0, 2'd2, 32'hA000, 4'h0, 32'h0);
    issue(OP_LW, 32'hA000, 0, 32'h0);
    step();
    flush_i = 1'b1;
    #3;
    chk("reqflush_req", data_req_o, 1);
    step();
    flush_i = 1'b0;
    clr();
    #3;
    chk("reqflush_req_drop", data_req_o, 0);
    chk("reqflush_stall", stall_o, 0);
    void'(req_exp.pop_front());
    step();

    push_req(0, 2'd2, 32'hB000, 4'h0, 32'h0);
    issue(OP_LW, 32'hB000, 0, 32'h0);
    data_addr_ok_i = 1'b1;
    step();
    data_addr_ok_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    chk("arst_req", data_req_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_rdata", rdata_o, 0);
    chk("arst_addr", data_addr_o, 0);
    chk("arst_badvaddr", badvaddr_o, 0);
    chk("arst_size", data_size_o, 0);
    clr();
    aluout_i = '0;
    step();
    rst_i = 1'b1;
    step();
    #3;
    chk("arst_idle_stall", stall_o, 0);
    chk("arst_idle_req", data_req_o, 0);
    step();

    mem_op(OP_LW, 32'hC000, 0, 32'h0, 2'd2, 4'h0, 32'h0,
           0, 1, 0, 32'h0BADF00D, 32'h0BADF00D);

    chk("req_queue_empty", req_exp.size(), 0);
    chk("rsp_queue_empty", rsp_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dsram_ctrl.md
Name: mem_dsram_ctrl

Overview:
- MEM-stage data-memory access controller; consumes the EX/MEM pipeline register outputs (memen, rmem, wmem, op, aluout, rdata2, except).
- Issues one SRAM-like data-bus transaction per load/store, stalls the pipeline until it completes, detects address errors, and returns the extended load result to the MEM/WB path.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus width; only 32 supported

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  MEM-stage flush (exception/eret)
- stall_i  in  1  MEM/WB register held this cycle (global stall, includes stall_o)
- memen_i  in  1  instruction is a memory access
- rmem_i  in  1  load
- wmem_i  in  1  store
- op_i  in  6  primary opcode
- aluout_i  in  32  effective address
- rdata2_i  in  32  store source data
- except_i  in  8  exception vector from earlier stages
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = write
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_addr_o  out  32  byte address
- data_wdata_o  out  32  lane-replicated write data
- data_wstrb_o  out  4  byte strobes
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  response valid
- data_rdata_i  in  32  read data
- rdata_o  out  32  extended load result
- stall_o  out  1  MEM-stage stall request
- except_o  out  8  except_i OR'd with AdEL/AdES
- badvaddr_o  out  32  faulting address (= aluout_i)

Behaviour:
Reset (rst_i = 0, async):
- state = IDLE; all outputs 0.

Opcodes:
- LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.

Address error (combinational):
- Half access with aluout_i[0] != 0, or word access with aluout_i[1:0] != 0, raises AdEL (load) or AdES (store).

Access gating:
- access = memen_i & ~flush_i & ~|except_o.
- A faulting or already-excepted instruction never issues a request.

Write path:
- Byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{rdata2[7:0]}}.
- Half: wstrb = 4'b0011 << addr[1:0], wdata = {2{rdata2[15:0]}}.
- Word: wstrb = 4'hF.
- For loads, wstrb = 0.

Load extension:
- Select the byte/half lane by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.

FSM:
- IDLE: if access, drive req = 1 and go to REQ (req is combinational in IDLE, so a zero-wait access starts the same cycle).
- REQ: req = 1; addr, wr, size, wdata and wstrb are held stable until addr_ok. On addr_ok go to WAIT; req falls the cycle after.
- WAIT: req = 0. On data_ok, capture the extended data into rdata_o (stores capture nothing) and go to DONE.
  - data_ok is never sampled in the same cycle as addr_ok; at most one transaction is outstanding.
- DONE: hold rdata_o; stall_o = 0. When stall_i = 0 (pipeline advances), go to IDLE.
- DRAIN: entered from WAIT on flush_i, or from REQ when flush_i and addr_ok coincide. Discard data_ok, then go to IDLE. stall_o = 1 while draining, so the next instruction waits.

stall_o:
- = 1 in IDLE when access, in REQ, in WAIT, and in DRAIN; 0 otherwise.

Boundary cases:
- flush_i in REQ without addr_ok: drop req next cycle, go to IDLE (no transaction was accepted).
- flush_i in DONE: go to IDLE.
- Reset mid-transaction: return to IDLE immediately. The bus slave must be reset by the same rst_i.

except_o and badvaddr_o are combinational from the current inputs.

Optional Feature:
DSRAM_PERF_CNT_EN:
- Defined: adds output ports perf_load_o, perf_store_o and perf_stall_o (32 bits each), counting completed loads, completed stores and cycles with stall_o = 1.
  - All three wrap at 2^32 and reset to 0.
- Undefined: no counters and no such ports; all other behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds:
  - opcode constants (OP_LB … OP_SW);
  - a size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - except bit indices EXC_ADEL = 4, EXC_ADES = 5;
  - the FSM state enum (IDLE, REQ, WAIT, DONE, DRAIN).
- One combinational sub-module, mem_lane_align, does op/addr decoding into size, wstrb, wdata, the address-error flag and load extension.

Test Plan:
- LW at 0x1000, addr_ok in cycle 0, data_ok in cycle 2 with 0xDEADBEEF → stall_o high for 3 cycles; rdata_o = 0xDEADBEEF; size = 2; wstrb = 0.
- SB at 0x2003 with rdata2 = 0x12345678 → wdata = 0x78787878, wstrb = 4'b1000, wr = 1; no rdata_o change.
- LH at 0x3002, rdata 0x8001_0000 → rdata_o = 0xFFFF8001. LHU at the same address → 0x00008001.
- LW at 0x4002 → no req; except_o[4] = 1; badvaddr_o = 0x4002; stall_o = 0. SH at 0x4001 → except_o[5] = 1.
- addr_ok held low for 5 cycles → req, addr and wdata stable throughout. Then flush_i asserted in WAIT → FSM enters DRAIN; the late data_ok does not update rdata_o; FSM returns to IDLE.
- Async reset asserted in WAIT → all outputs 0 immediately; FSM in IDLE after release.
